// File: rtl/led_frame_buffer_if.sv
// Pixel write port of the LED frame buffer: valid/ready handshake carrying row, column and colour.
interface led_frame_buffer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_row;
  logic [2:0] wr_col;
  logic [1:0] wr_color;

  modport master (output wr_valid, output wr_row, output wr_col, output wr_color, input wr_ready);
  modport slave  (input wr_valid, input wr_row, input wr_col, input wr_color, output wr_ready);
endinterface

// File: rtl/led_frame_buffer.sv
// Double-buffered 8x8 red/green frame store; the back bank is written pixel by pixel and
// swapped to the front on the scan driver's frame boundary (or after a timeout).
module led_frame_buffer #(
  parameter int SWAP_TIMEOUT = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  led_frame_buffer_if.slave    wr,
  input  logic                 clear_req,
  input  logic                 swap_req,
  input  logic                 frame_start,
  output logic                 busy,
  output logic                 swap_done,
  output logic [7:0][7:0]      red_array,
  output logic [7:0][7:0]      green_array
);

  localparam int CW = (SWAP_TIMEOUT > 2) ? $clog2(SWAP_TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((SWAP_TIMEOUT > 0) ? SWAP_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR     = 2'd1,
    SWAP_WAIT = 2'd2
  } state_t;

  state_t                 state_r;
  logic [1:0][7:0][7:0]   red_bank_r;
  logic [1:0][7:0][7:0]   green_bank_r;
  logic                   front_r;
  logic [2:0]             row_r;
  logic                   swap_pend_r;
  logic [CW-1:0]          wait_r;
  logic                   ready_r;
  logic                   busy_r;
  logic                   done_r;

  logic                   back_s;
  logic                   accept_s;
  logic                   timeout_hit_s;

  assign back_s        = ~front_r;
  assign accept_s      = wr.wr_valid && ready_r;
  assign timeout_hit_s = (SWAP_TIMEOUT != 0) && (wait_r == TO_LAST);

  // Control FSM, bank storage and registered status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      red_bank_r   <= '0;
      green_bank_r <= '0;
      front_r      <= 1'b0;
      row_r        <= 3'd0;
      swap_pend_r  <= 1'b0;
      wait_r       <= '0;
      ready_r      <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            red_bank_r[back_s][wr.wr_row][wr.wr_col]   <= wr.wr_color[0];
            green_bank_r[back_s][wr.wr_row][wr.wr_col] <= wr.wr_color[1];
          end
          if (clear_req) begin
            state_r     <= CLEAR;
            row_r       <= 3'd0;
            swap_pend_r <= swap_req;
            ready_r     <= 1'b0;
            busy_r      <= 1'b1;
          end else if (swap_req) begin
            state_r <= SWAP_WAIT;
            wait_r  <= '0;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        CLEAR: begin
          red_bank_r[back_s][row_r]   <= 8'h00;
          green_bank_r[back_s][row_r] <= 8'h00;
          if (row_r == 3'd7) begin
            // A swap request landing on the last clear row still chains into the swap
            if (swap_pend_r || swap_req) begin
              state_r <= SWAP_WAIT;
              wait_r  <= '0;
            end else begin
              state_r <= IDLE;
              ready_r <= 1'b1;
              busy_r  <= 1'b0;
            end
            swap_pend_r <= 1'b0;
          end else begin
            row_r <= row_r + 3'd1;
            if (swap_req) begin
              swap_pend_r <= 1'b1;
            end
          end
        end
        SWAP_WAIT: begin
          if (frame_start || timeout_hit_s) begin
            front_r <= ~front_r;
            state_r <= IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            wait_r <= wait_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign wr.wr_ready  = ready_r;
  assign busy         = busy_r;
  assign swap_done    = done_r;
  assign red_array    = red_bank_r[front_r];
  assign green_array  = green_bank_r[front_r];

endmodule

// File: tb/tb_led_frame_buffer.sv
// Self-checking bench for led_frame_buffer: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a pixel-level behavioural model.
module tb_led_frame_buffer;
  localparam int TO = 16;

  logic            clock = 1'b0;
  logic            reset;
  logic            clear_req, swap_req, frame_start;
  logic            busy, swap_done;
  logic [7:0][7:0] red_array, green_array;
  int              checks = 0;
  int              failures = 0;

  led_frame_buffer_if bus ();

  led_frame_buffer #(.SWAP_TIMEOUT(TO)) dut (
    .clock       (clock),
    .reset       (reset),
    .wr          (bus),
    .clear_req   (clear_req),
    .swap_req    (swap_req),
    .frame_start (frame_start),
    .busy        (busy),
    .swap_done   (swap_done),
    .red_array   (red_array),
    .green_array (green_array)
  );

  always #5 clock = ~clock;

  // Reference model: two banks of 64 colour pixels and a front selector
  logic [1:0] m_pix [2][64];
  logic       m_front;
  int         m_mode;   // 0 idle, 1 clearing, 2 waiting for frame
  int         m_clr_row, m_wait;
  logic       m_pend, m_done, m_on = 1'b0, m_rst = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    logic [63:0] er, eg;
    int bk;
    if (reset) begin
      for (int b = 0; b < 2; b++) for (int p = 0; p < 64; p++) m_pix[b][p] = 2'b00;
      m_front = 1'b0; m_mode = 0; m_pend = 1'b0; m_done = 1'b0;
      m_on = 1'b1; m_rst = 1'b1;
    end else if (m_on) begin
      m_rst = 1'b0;
      m_done = 1'b0;
      bk = m_front ? 0 : 1;
      if (m_mode == 0) begin
        if (bus.wr_valid) m_pix[bk][bus.wr_row * 8 + bus.wr_col] = bus.wr_color;
        if (clear_req) begin m_mode = 1; m_clr_row = 0; m_pend = swap_req; end
        else if (swap_req) begin m_mode = 2; m_wait = 0; end
      end else if (m_mode == 1) begin
        for (int c = 0; c < 8; c++) m_pix[bk][m_clr_row * 8 + c] = 2'b00;
        if (swap_req) m_pend = 1'b1;
        if (m_clr_row == 7) begin
          m_mode = m_pend ? 2 : 0; m_wait = 0; m_pend = 1'b0;
        end else m_clr_row++;
      end else begin
        if (frame_start || m_wait == TO - 1) begin
          m_front = ~m_front; m_mode = 0; m_done = 1'b1;
        end else m_wait++;
      end
    end
    #1;
    if (m_on) begin
      for (int p = 0; p < 64; p++) begin
        er[p] = m_pix[m_front][p][0];
        eg[p] = m_pix[m_front][p][1];
      end
      chk("model_busy", 64'(busy), 64'(m_mode != 0));
      chk("model_swap_done", 64'(swap_done), 64'(m_done));
      chk("model_red", red_array, er);
      chk("model_green", green_array, eg);
      if (!m_rst) chk("model_wr_ready", 64'(bus.wr_ready), 64'(m_mode == 0));
    end
  end

  task automatic wr_px(int r, int c, logic [1:0] col);
    bus.wr_valid = 1'b1; bus.wr_row = 3'(r); bus.wr_col = 3'(c); bus.wr_color = col;
    @(negedge clock);
    bus.wr_valid = 1'b0;
  endtask

  initial begin
    int n, nr;
    reset = 1'b1; clear_req = 1'b0; swap_req = 1'b0; frame_start = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_row = 3'd0; bus.wr_col = 3'd0; bus.wr_color = 2'b00;
    repeat (2) @(negedge clock);
    chk("rst_red", red_array, 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    reset = 1'b0;
    @(posedge clock); #2;
    chk("rst_ready", 64'(bus.wr_ready), 64'h1);
    chk("rst_swap_done", 64'(swap_done), 64'h0);
    chk("rst_green", green_array, 64'h0);
    @(negedge clock);

    // Write then swap on frame_start
    wr_px(3, 5, 2'b01);
    wr_px(0, 0, 2'b11);
    chk("back_invisible", red_array | green_array, 64'h0);
    swap_req = 1'b1; @(negedge clock); swap_req = 1'b0;
    repeat (3) @(negedge clock);
    frame_start = 1'b1;
    @(posedge clock); #2;
    chk("swap_done_pulse", 64'(swap_done), 64'h1);
    chk("swap_red", red_array, 64'h0000_0000_2000_0001);
    chk("swap_green", green_array, 64'h0000_0000_0000_0001);
    @(negedge clock); frame_start = 1'b0;
    @(posedge clock); #2;
    chk("swap_done_single", 64'(swap_done), 64'h0);
    @(negedge clock);

    // Clear timing
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) wr_px(r, c, 2'b10);
    clear_req = 1'b1;
    @(posedge clock); #2; clear_req = 1'b0;
    n = 0; nr = 0;
    while (busy && n < 20) begin
      n++;
      if (!bus.wr_ready) nr++;
      @(posedge clock); #2;
    end
    chk("clear_busy_cycles", 64'(n), 64'd8);
    chk("clear_notready_cycles", 64'(nr), 64'd8);
    @(negedge clock);
    swap_req = 1'b1; @(negedge clock); swap_req = 1'b0;
    @(negedge clock); frame_start = 1'b1;
    @(posedge clock); #2;
    chk("clear_green", green_array, 64'h0);
    chk("clear_red", red_array, 64'h0);
    @(negedge clock); frame_start = 1'b0;

    // Clear and swap together: back bank holds old red pixels that must vanish
    clear_req = 1'b1; swap_req = 1'b1;
    @(negedge clock); clear_req = 1'b0; swap_req = 1'b0;
    repeat (10) @(negedge clock);
    chk("cs_still_busy", 64'(busy), 64'h1);
    frame_start = 1'b1;
    @(posedge clock); #2;
    chk("cs_swap_done", 64'(swap_done), 64'h1);
    chk("cs_red", red_array, 64'h0);
    chk("cs_green", green_array, 64'h0);
    @(negedge clock); frame_start = 1'b0;

    // Timeout swap without frame_start
    wr_px(7, 7, 2'b11);
    swap_req = 1'b1;
    @(posedge clock); #2; swap_req = 1'b0;
    n = 0;
    while (!swap_done && n < 40) begin
      @(posedge clock); #2; n++;
    end
    chk("timeout_cycles", 64'(n), 64'd16);
    chk("timeout_red", red_array, 64'h8000_0000_0000_0000);
    chk("timeout_green", green_array, 64'h8000_0000_0000_0000);
    @(negedge clock);

    // Reset on CLEAR cycle 4 aborts everything
    wr_px(1, 1, 2'b01);
    clear_req = 1'b1; @(negedge clock); clear_req = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1; @(negedge clock); reset = 1'b0;
    @(posedge clock); #2;
    chk("abort_busy", 64'(busy), 64'h0);
    chk("abort_swap_done", 64'(swap_done), 64'h0);
    chk("abort_arrays", red_array | green_array, 64'h0);
    chk("abort_ready", 64'(bus.wr_ready), 64'h1);
    @(negedge clock);

    // Randomized traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      bus.wr_valid = ($urandom_range(0, 1) == 1);
      bus.wr_row   = 3'($urandom_range(0, 7));
      bus.wr_col   = 3'($urandom_range(0, 7));
      bus.wr_color = 2'($urandom_range(0, 3));
      clear_req    = ($urandom_range(0, 99) < 3);
      swap_req     = ($urandom_range(0, 99) < 5);
      frame_start  = ($urandom_range(0, 99) < 8);
      reset        = ($urandom_range(0, 999) < 3);
      @(negedge clock);
    end
    bus.wr_valid = 1'b0; clear_req = 1'b0; swap_req = 1'b0; frame_start = 1'b0; reset = 1'b0;
    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
